// File: rtl/evg_tx_framer_if.sv
// Event-link transmit framer bus: event/beacon requests, dbus, shared-data buffer
// and frame control on the input side, link word and status on the output side.
interface evg_tx_framer_if #(
    parameter int SD_DEPTH = 64
);
    localparam int SD_AW = $clog2(SD_DEPTH);

    logic [7:0]       ev_code;
    logic             ev_valid;
    logic             ev_ready;
    logic             beacon_req;
    logic [7:0]       dbus;
    logic             sd_wr_en;
    logic [SD_AW-1:0] sd_wr_addr;
    logic [7:0]       sd_wr_data;
    logic             sd_send;
    logic [7:0]       sd_addr;
    logic [SD_AW:0]   sd_len;
    logic             sd_busy;
    logic             sd_err;
    logic [15:0]      tx_data;
    logic [1:0]       tx_charisk;

    modport master (
        output ev_code, ev_valid, beacon_req, dbus,
        output sd_wr_en, sd_wr_addr, sd_wr_data, sd_send, sd_addr, sd_len,
        input  ev_ready, sd_busy, sd_err, tx_data, tx_charisk
    );

    modport slave (
        input  ev_code, ev_valid, beacon_req, dbus,
        input  sd_wr_en, sd_wr_addr, sd_wr_data, sd_send, sd_addr, sd_len,
        output ev_ready, sd_busy, sd_err, tx_data, tx_charisk
    );
endinterface

// File: rtl/evg_tx_framer.sv
// Transmit framer for the 16-bit event link: upper byte carries beacons/commas/events,
// lower byte carries dbus or shared-data frames. Define EVG_TX_CSUM_EN to append a 16-bit checksum.
module evg_tx_framer #(
    parameter int COMMA_PERIOD = 4,
    parameter int SD_DEPTH     = 64,
    localparam int SD_AW       = $clog2(SD_DEPTH)
) (
    input logic            clk,
    input logic            resetn,
    evg_tx_framer_if.slave bus
);
    localparam int             CW           = $clog2(COMMA_PERIOD);
    localparam logic [CW-1:0]  COMMA_RELOAD = CW'(COMMA_PERIOD - 1);
    localparam logic [SD_AW:0] LEN_MAX      = (SD_AW + 1)'(SD_DEPTH);
    localparam logic [7:0]     K_COMMA      = 8'hBC;
    localparam logic [7:0]     BEACON       = 8'h7E;
    localparam logic [7:0]     K_SOF        = 8'h1C;
    localparam logic [7:0]     K_EOF        = 8'h3C;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SOF  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_EOF  = 3'd4;
`ifdef EVG_TX_CSUM_EN
    localparam logic [2:0] S_CSH  = 3'd5;
    localparam logic [2:0] S_CSL  = 3'd6;

    function automatic logic [15:0] csum16(input logic [15:0] sum);
        return ~sum + 16'd1;
    endfunction
`endif

    // state_r names the lower-byte phase currently on tx_data
    logic [CW-1:0]    comma_cnt_r;
    logic [2:0]       state_r;
    logic [SD_AW-1:0] idx_r;
    logic [SD_AW:0]   len_r;
    logic [7:0]       addr_r;
    logic [7:0]       sd_buf_r [SD_DEPTH];
    logic [15:0]      tx_data_r;
    logic [1:0]       tx_charisk_r;
    logic             sd_busy_r;
    logic             sd_err_r;
`ifdef EVG_TX_CSUM_EN
    logic [15:0]      sum_r;
    logic [15:0]      sum_next_s;
    logic [15:0]      csum_s;
`endif

    logic             comma_due_s;
    logic             ev_ready_s;
    logic             ev_take_s;
    logic             ev_bad_s;
    logic [7:0]       up_byte_s;
    logic             up_k_s;
    logic [CW-1:0]    cnt_next_s;
    logic             busy_s;
    logic             len_bad_s;
    logic             send_ok_s;
    logic             err_s;
    logic             wr_ok_s;
    logic [2:0]       state_next_s;
    logic [SD_AW-1:0] idx_next_s;
    logic [7:0]       lo_byte_s;
    logic             lo_k_s;

    assign comma_due_s = (comma_cnt_r == {CW{1'b0}});
    assign ev_ready_s  = resetn & ~bus.beacon_req & ~comma_due_s;
    assign ev_take_s   = ev_ready_s & bus.ev_valid;
    assign ev_bad_s    = ev_take_s & ((bus.ev_code == BEACON) | (bus.ev_code == K_COMMA));
    assign busy_s      = (state_r != S_IDLE);
    assign len_bad_s   = (bus.sd_len == {(SD_AW + 1){1'b0}}) | (bus.sd_len > LEN_MAX);
    assign send_ok_s   = bus.sd_send & ~busy_s & ~len_bad_s;
    assign wr_ok_s     = bus.sd_wr_en & ~busy_s;
    assign err_s       = (bus.sd_send & (busy_s | len_bad_s)) | (bus.sd_wr_en & busy_s) | ev_bad_s;

    // Upper byte selection and comma scheduling
    always_comb begin
        up_byte_s  = 8'h00;
        up_k_s     = 1'b0;
        cnt_next_s = comma_cnt_r;
        if (bus.beacon_req) begin
            up_byte_s  = BEACON;
            cnt_next_s = comma_due_s ? comma_cnt_r : comma_cnt_r - CW'(1);
        end else if (comma_due_s) begin
            up_byte_s  = K_COMMA;
            up_k_s     = 1'b1;
            cnt_next_s = COMMA_RELOAD;
        end else begin
            up_byte_s  = (ev_take_s && !ev_bad_s) ? bus.ev_code : 8'h00;
            cnt_next_s = comma_cnt_r - CW'(1);
        end
    end

    // Lower byte frame sequencing; the byte registered is that of the next phase
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        lo_byte_s    = bus.dbus;
        lo_k_s       = 1'b0;
`ifdef EVG_TX_CSUM_EN
        sum_next_s   = sum_r;
        csum_s       = csum16(sum_r);
`endif
        case (state_r)
            S_IDLE: begin
                if (send_ok_s) begin
                    state_next_s = S_SOF;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SOF:  state_next_s = S_ADDR;
            S_ADDR: begin
                state_next_s = S_DATA;
                idx_next_s   = {SD_AW{1'b0}};
            end
            S_DATA: begin
                if ({1'b0, idx_r} == len_r - (SD_AW + 1)'(1)) begin
                    state_next_s = S_EOF;
                end else begin
                    idx_next_s = idx_r + SD_AW'(1);
                end
            end
`ifdef EVG_TX_CSUM_EN
            S_EOF:  state_next_s = S_CSH;
            S_CSH:  state_next_s = S_CSL;
            S_CSL:  state_next_s = S_IDLE;
`else
            S_EOF:  state_next_s = S_IDLE;
`endif
            default: state_next_s = S_IDLE;
        endcase

        case (state_next_s)
            S_IDLE: lo_byte_s = bus.dbus;
            S_SOF: begin
                lo_byte_s = K_SOF;
                lo_k_s    = 1'b1;
`ifdef EVG_TX_CSUM_EN
                sum_next_s = {8'h00, bus.sd_addr};
`endif
            end
            S_ADDR: lo_byte_s = addr_r;
            S_DATA: begin
                lo_byte_s = sd_buf_r[idx_next_s];
`ifdef EVG_TX_CSUM_EN
                sum_next_s = sum_r + {8'h00, sd_buf_r[idx_next_s]};
`endif
            end
            S_EOF: begin
                lo_byte_s = K_EOF;
                lo_k_s    = 1'b1;
            end
`ifdef EVG_TX_CSUM_EN
            S_CSH:  lo_byte_s = csum_s[15:8];
            S_CSL:  lo_byte_s = csum_s[7:0];
`endif
            default: lo_byte_s = bus.dbus;
        endcase
    end

    // Control state and registered link outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            comma_cnt_r  <= {CW{1'b0}};
            state_r      <= S_IDLE;
            idx_r        <= {SD_AW{1'b0}};
            len_r        <= {(SD_AW + 1){1'b0}};
            addr_r       <= 8'h00;
            tx_data_r    <= 16'h0000;
            tx_charisk_r <= 2'b00;
            sd_busy_r    <= 1'b0;
            sd_err_r     <= 1'b0;
`ifdef EVG_TX_CSUM_EN
            sum_r        <= 16'h0000;
`endif
        end else begin
            comma_cnt_r  <= cnt_next_s;
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            if (send_ok_s) begin
                len_r  <= bus.sd_len;
                addr_r <= bus.sd_addr;
            end
            tx_data_r    <= {up_byte_s, lo_byte_s};
            tx_charisk_r <= {up_k_s, lo_k_s};
            sd_busy_r    <= (state_next_s != S_IDLE);
            sd_err_r     <= err_s;
`ifdef EVG_TX_CSUM_EN
            sum_r        <= sum_next_s;
`endif
        end
    end

    // Shared-data byte buffer; writes are only taken between frames
    always_ff @(posedge clk) begin
        if (resetn && wr_ok_s) begin
            sd_buf_r[bus.sd_wr_addr] <= bus.sd_wr_data;
        end
    end

    assign bus.ev_ready   = ev_ready_s;
    assign bus.tx_data    = tx_data_r;
    assign bus.tx_charisk = tx_charisk_r;
    assign bus.sd_busy    = sd_busy_r;
    assign bus.sd_err     = sd_err_r;
endmodule

// File: tb/tb_evg_tx_framer.sv
// Scoreboard bench for evg_tx_framer: the driver predicts each link word, a negedge monitor compares.
module tb_evg_tx_framer;
    localparam int COMMA_RELOAD = 3;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [1:0]  k;
        logic        busy;
        logic        err;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       k;
    } lo_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bcnt = 0;
    logic ev_taken = 1'b0;
    exp_t sbq[$];
    lo_t  lo_q[$];
    logic [7:0] fdat [4];

    evg_tx_framer_if #(.SD_DEPTH(64)) bif ();

    evg_tx_framer #(.COMMA_PERIOD(4), .SD_DEPTH(64)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            checks++;
            if ({bif.tx_data, bif.tx_charisk, bif.sd_busy, bif.sd_err} !== {e.data, e.k, e.busy, e.err}) begin
                errors++;
                $display("FAIL link cyc=%0d got data=%h k=%b busy=%b err=%b want data=%h k=%b busy=%b err=%b",
                         cyc, bif.tx_data, bif.tx_charisk, bif.sd_busy, bif.sd_err, e.data, e.k, e.busy, e.err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic push_lo(input logic [7:0] b, input logic k);
        lo_t l;
        l.b = b;
        l.k = k;
        lo_q.push_back(l);
    endtask

    // Queue the frame bytes that follow an accepted sd_send
    task automatic frame_exp(input logic [7:0] a, input int n, input logic [15:0] csum);
        push_lo(8'h1C, 1'b1);
        push_lo(a, 1'b0);
        for (int i = 0; i < n; i++) push_lo(fdat[i], 1'b0);
        push_lo(8'h3C, 1'b1);
`ifdef EVG_TX_CSUM_EN
        push_lo(csum[15:8], 1'b0);
        push_lo(csum[7:0], 1'b0);
`else
        if (csum == 16'h0000) push_lo(8'h00, 1'b0);
`endif
    endtask

    // Predict the word for the inputs already driven, then advance one clock
    task automatic step(input logic exp_err);
        exp_t e;
        lo_t  l;
        logic rdy;
        logic [7:0] up;
        logic upk;
        logic err;
        #1;
        rdy = !bif.beacon_req && (bcnt != 0);
        chk("ev_ready", {31'd0, bif.ev_ready}, {31'd0, rdy});
        ev_taken = bif.ev_valid && rdy;
        err = exp_err;
        upk = 1'b0;
        up = 8'h00;
        if (bif.beacon_req) begin
            up = 8'h7E;
            if (bcnt != 0) bcnt--;
        end else if (bcnt == 0) begin
            up = 8'hBC;
            upk = 1'b1;
            bcnt = COMMA_RELOAD;
        end else begin
            bcnt--;
            if (ev_taken) begin
                if (bif.ev_code == 8'h7E || bif.ev_code == 8'hBC) err = 1'b1;
                else up = bif.ev_code;
            end
        end
        if (lo_q.size() > 0) begin
            l = lo_q.pop_front();
            e.data = {up, l.b};
            e.k = {upk, l.k};
            e.busy = 1'b1;
        end else begin
            e.data = {up, bif.dbus};
            e.k = {upk, 1'b0};
            e.busy = 1'b0;
        end
        e.err = err;
        e.cyc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_tx_data", {16'd0, bif.tx_data}, 32'd0);
        chk("rst_charisk", {30'd0, bif.tx_charisk}, 32'd0);
        chk("rst_busy", {31'd0, bif.sd_busy}, 32'd0);
        chk("rst_err", {31'd0, bif.sd_err}, 32'd0);
        chk("rst_ev_ready", {31'd0, bif.ev_ready}, 32'd0);
    endtask

    initial begin
        logic [7:0] codes [10];
        int k;
        codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7E, 8'hBC};
        bif.ev_code = 8'h00;   bif.ev_valid = 1'b0;  bif.beacon_req = 1'b0;
        bif.dbus = 8'h00;      bif.sd_wr_en = 1'b0;  bif.sd_wr_addr = 6'd0;
        bif.sd_wr_data = 8'h00; bif.sd_send = 1'b0;  bif.sd_addr = 8'h00;
        bif.sd_len = 7'd0;

        // 1: reset state, then comma every 4 cycles and dbus passthrough
        bif.ev_valid = 1'b1;
        repeat (3) @(posedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        bif.ev_valid = 1'b0;
        resetn = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 9; i++) begin
            bif.dbus = 8'hA0 + 8'(i);
            step(1'b0);
        end

        // 2: beacon on a comma-due cycle, event held pending
        for (int g = 0; g < 8 && bcnt != 0; g++) step(1'b0);
        bif.ev_valid = 1'b1; bif.ev_code = 8'h5A;
        bif.beacon_req = 1'b1;
        step(1'b0);
        bif.beacon_req = 1'b0;
        step(1'b0);
        step(1'b0);
        bif.ev_valid = 1'b0;
        repeat (5) step(1'b0);

        // 3: event stream with ev_valid held, including the two reserved codes
        k = 0;
        bif.ev_valid = 1'b1;
        for (int g = 0; g < 40 && k < 10; g++) begin
            bif.ev_code = codes[k];
            step(1'b0);
            if (ev_taken) k++;
        end
        bif.ev_valid = 1'b0;
        if (k != 10) begin
            errors++;
            $display("FAIL ev_stream got %0d codes want 10", k);
        end

        // 4: three-byte frame, last write in the same cycle as the send
        bif.sd_wr_en = 1'b1;
        bif.sd_wr_addr = 6'd0; bif.sd_wr_data = 8'h11; step(1'b0);
        bif.sd_wr_addr = 6'd1; bif.sd_wr_data = 8'h22; step(1'b0);
        bif.sd_wr_addr = 6'd2; bif.sd_wr_data = 8'h33;
        bif.sd_send = 1'b1; bif.sd_addr = 8'h05; bif.sd_len = 7'd3;
        fdat = '{8'h11, 8'h22, 8'h33, 8'h00};
        frame_exp(8'h05, 3, 16'hFF95);   // -(0x05+0x11+0x22+0x33)
        step(1'b0);
        bif.sd_wr_en = 1'b0; bif.sd_send = 1'b0;
        repeat (9) step(1'b0);

        // 5: rejected sends and writes
        bif.sd_send = 1'b1; bif.sd_addr = 8'h80; bif.sd_len = 7'd0;  step(1'b1);
        bif.sd_len = 7'd65; step(1'b1);
        bif.sd_len = 7'd2;
        fdat = '{8'h11, 8'h22, 8'h00, 8'h00};
        frame_exp(8'h80, 2, 16'hFF4D);   // -(0x80+0x11+0x22)
        step(1'b0);
        bif.sd_send = 1'b0;
        step(1'b0);
        bif.sd_send = 1'b1; bif.sd_len = 7'd1; step(1'b1);
        bif.sd_send = 1'b0;
        bif.sd_wr_en = 1'b1; bif.sd_wr_addr = 6'd0; bif.sd_wr_data = 8'h99; step(1'b1);
        bif.sd_wr_en = 1'b0;
        repeat (6) step(1'b0);
        bif.sd_send = 1'b1; bif.sd_addr = 8'h01; bif.sd_len = 7'd1;
        fdat = '{8'h11, 8'h00, 8'h00, 8'h00};
        frame_exp(8'h01, 1, 16'hFFEE);   // -(0x01+0x11)
        step(1'b0);
        bif.sd_send = 1'b0;
        repeat (6) step(1'b0);

        // 6: reset during DATA, then a clean frame
        bif.sd_send = 1'b1; bif.sd_addr = 8'h05; bif.sd_len = 7'd3;
        fdat = '{8'h11, 8'h22, 8'h33, 8'h00};
        frame_exp(8'h05, 3, 16'hFF95);
        step(1'b0);
        bif.sd_send = 1'b0;
        step(1'b0);
        step(1'b0);
        resetn = 1'b0;
        lo_q.delete();
        @(posedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        resetn = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 3; i++) begin
            bif.dbus = 8'h60 + 8'(i);
            step(1'b0);
        end
        bif.sd_send = 1'b1; bif.sd_addr = 8'h42; bif.sd_len = 7'd3;
        frame_exp(8'h42, 3, 16'hFF58);   // -(0x42+0x66)
        step(1'b0);
        bif.sd_send = 1'b0;
        repeat (9) step(1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
